// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-detects active-low push buttons.
// Define KEY_CONDITIONER_LONG_PRESS_EN to build the per-key long-press detector.
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] sync_a;
  logic [N_KEYS-1:0] sync_b;
  logic [N_KEYS-1:0] level;
  logic [DW-1:0]     deb_cnt [N_KEYS];

  // level is the accepted debounced state; pressed and the pulses are registered
  // from it one cycle later so level and edges come out of the same flop stage.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync_a        <= '0;
      sync_b        <= '0;
      level         <= '0;
      pressed       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync_a <= ~KEY;
      sync_b <= sync_a;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (sync_b[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= ~level[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
      pressed       <= level;
      press_pulse   <= level & ~pressed;
      release_pulse <= ~level & pressed;
    end
  end

`ifdef KEY_CONDITIONER_LONG_PRESS_EN
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_cnt [N_KEYS];

  // Counter saturates at HOLD_MAX, so the HOLD_LAST match happens once per press.
  always_ff @(posedge CLK) begin
    if (reset) begin
      long_press <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (!pressed[i]) begin
          hold_cnt[i]   <= '0;
          long_press[i] <= 1'b0;
        end else begin
          if (hold_cnt[i] != HOLD_MAX) begin
            hold_cnt[i] <= hold_cnt[i] + 1'b1;
          end
          long_press[i] <= (hold_cnt[i] == HOLD_LAST);
        end
      end
    end
  end
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, N_KEYS=2).
// Pulse events are predicted into a time-ordered scoreboard and matched by a monitor.
module tb_key_conditioner;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] KEY = 2'b11;
  logic [1:0] pressed, press_pulse, release_pulse, long_press;

`ifdef KEY_CONDITIONER_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int unsigned LAT  = 7;   // drive negedge -> output negedge
  localparam int unsigned HOLD = 10;

  key_conditioner #(
    .N_KEYS(2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .KEY(KEY),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press(long_press)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int unsigned total_cnt = 0;
  int unsigned pass_cnt = 0;

  // kind: 0 press_pulse, 1 release_pulse, 2 long_press
  typedef struct {
    int unsigned cyc;
    int unsigned key;
    int unsigned kind;
  } ev_t;

  ev_t exp_q[$];

  function automatic int unsigned ev_ord(input ev_t e);
    return e.cyc * 8 + e.key * 3 + e.kind;
  endfunction

  function automatic void push_ev(input int unsigned c, input int unsigned k, input int unsigned kd);
    ev_t e;
    int unsigned pos;
    e.cyc = c;
    e.key = k;
    e.kind = kd;
    pos = exp_q.size();
    for (int unsigned i = 0; i < exp_q.size(); i++) begin
      if (ev_ord(exp_q[i]) > ev_ord(e)) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endfunction

  // Drive one key at a negedge and predict its resulting pulses.
  task automatic drive_key(input int unsigned k, input logic lvl, input bit hold_long);
    KEY[k] = lvl;
    push_ev(cyc + LAT, k, lvl ? 1 : 0);
    if (!lvl && hold_long && LONG_EN) push_ev(cyc + LAT + HOLD, k, 2);
  endtask

  // Scoreboard consumer: every observed pulse must match the next predicted event.
  always @(negedge CLK) begin
    ev_t e;
    logic obs;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      total_cnt++;
      $display("FAIL missed_event key%0d kind%0d: observed none, required at cycle %0d (now %0d)",
               exp_q[0].key, exp_q[0].kind, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    for (int k = 0; k < 2; k++) begin
      for (int kd = 0; kd < 3; kd++) begin
        obs = (kd == 0) ? press_pulse[k] : (kd == 1) ? release_pulse[k] : long_press[k];
        if (obs === 1'b1) begin
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_pulse key%0d kind%0d: observed at cycle %0d, required none",
                     k, kd, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc !== cyc || e.key != k || e.kind != kd) begin
              $display("FAIL pulse_order: observed key%0d kind%0d cycle %0d, required key%0d kind%0d cycle %0d",
                       k, kd, cyc, e.key, e.kind, e.cyc);
            end else begin
              pass_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    KEY = 2'b11;
    repeat (3) @(negedge CLK);
    total_cnt++;
    if ({pressed, press_pulse, release_pulse, long_press} !== 8'h00) begin
      $display("FAIL reset_outputs: observed %b, required 00000000",
               {pressed, press_pulse, release_pulse, long_press});
    end else pass_cnt++;
    reset = 1'b0;
    repeat (6) @(negedge CLK);
    total_cnt++;
    if ({pressed, press_pulse, release_pulse, long_press} !== 8'h00) begin
      $display("FAIL idle_outputs: observed %b, required 00000000",
               {pressed, press_pulse, release_pulse, long_press});
    end else pass_cnt++;
  endtask

  task automatic test_clean_press();
    drive_key(0, 1'b0, 1'b1);
    repeat (6) @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b00) $display("FAIL press_early: observed %b, required 00", pressed);
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b01 || press_pulse !== 2'b01)
      $display("FAIL press_latency: observed pressed=%b pulse=%b, required 01/01", pressed, press_pulse);
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b01 || press_pulse !== 2'b00)
      $display("FAIL press_width: observed pressed=%b pulse=%b, required 01/00", pressed, press_pulse);
    else pass_cnt++;
    repeat (9) @(negedge CLK);
    total_cnt++;
    if (long_press !== {1'b0, LONG_EN})
      $display("FAIL long_latency: observed %b, required %b", long_press, {1'b0, LONG_EN});
    else pass_cnt++;
    repeat (5) @(negedge CLK);
    drive_key(0, 1'b1, 1'b0);
    repeat (6) @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b01) $display("FAIL release_early: observed %b, required 01", pressed);
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b00 || release_pulse !== 2'b01)
      $display("FAIL release_latency: observed pressed=%b pulse=%b, required 00/01", pressed, release_pulse);
    else pass_cnt++;
    repeat (3) @(negedge CLK);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL clean_press_pending: observed %0d events left, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    KEY[0] = 1'b0;
    repeat (3) @(negedge CLK);
    KEY[0] = 1'b1;
    repeat (10) @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b00) $display("FAIL glitch_rejected: observed %b, required 00", pressed);
    else pass_cnt++;
    drive_key(0, 1'b0, 1'b0);
    repeat (6) @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b00) $display("FAIL glitch_retry_early: observed %b, required 00", pressed);
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b01 || press_pulse !== 2'b01)
      $display("FAIL glitch_retry: observed pressed=%b pulse=%b, required 01/01", pressed, press_pulse);
    else pass_cnt++;
    drive_key(0, 1'b1, 1'b0);
    repeat (10) @(negedge CLK);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL glitch_pending: observed %0d events left, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_long_press();
    for (int r = 0; r < 2; r++) begin
      drive_key(0, 1'b0, 1'b1);
      repeat (7) @(negedge CLK);
      total_cnt++;
      if (pressed !== 2'b01) $display("FAIL long_pressed_r%0d: observed %b, required 01", r, pressed);
      else pass_cnt++;
      repeat (9) @(negedge CLK);
      total_cnt++;
      if (long_press !== 2'b00) $display("FAIL long_early_r%0d: observed %b, required 00", r, long_press);
      else pass_cnt++;
      @(negedge CLK);
      total_cnt++;
      if (long_press !== {1'b0, LONG_EN})
        $display("FAIL long_fire_r%0d: observed %b, required %b", r, long_press, {1'b0, LONG_EN});
      else pass_cnt++;
      repeat (20) @(negedge CLK);
      total_cnt++;
      if (pressed !== 2'b01 || long_press !== 2'b00)
        $display("FAIL long_held_r%0d: observed pressed=%b long=%b, required 01/00", r, pressed, long_press);
      else pass_cnt++;
      drive_key(0, 1'b1, 1'b0);
      repeat (10) @(negedge CLK);
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL long_pending: observed %0d events left, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_press();
    int unsigned m;
    drive_key(0, 1'b0, 1'b0);
    repeat (7) @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b01) $display("FAIL rmp_pressed: observed %b, required 01", pressed);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge CLK);
    total_cnt++;
    if ({pressed, press_pulse, release_pulse, long_press} !== 8'h00)
      $display("FAIL rmp_cleared: observed %b, required 00000000",
               {pressed, press_pulse, release_pulse, long_press});
    else pass_cnt++;
    reset = 1'b0;
    m = cyc;
    push_ev(m + LAT, 0, 0);
    if (LONG_EN) push_ev(m + LAT + HOLD, 0, 2);
    repeat (6) @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b00) $display("FAIL rmp_early: observed %b, required 00", pressed);
    else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b01 || press_pulse !== 2'b01)
      $display("FAIL rmp_repress: observed pressed=%b pulse=%b, required 01/01", pressed, press_pulse);
    else pass_cnt++;
    repeat (12) @(negedge CLK);
    drive_key(0, 1'b1, 1'b0);
    repeat (10) @(negedge CLK);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL rmp_pending: observed %0d events left, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    drive_key(0, 1'b0, 1'b1);
    drive_key(1, 1'b0, 1'b1);
    repeat (7) @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b11 || press_pulse !== 2'b11)
      $display("FAIL simul_press: observed pressed=%b pulse=%b, required 11/11", pressed, press_pulse);
    else pass_cnt++;
    repeat (12) @(negedge CLK);
    drive_key(0, 1'b1, 1'b0);
    drive_key(1, 1'b1, 1'b0);
    repeat (7) @(negedge CLK);
    total_cnt++;
    if (pressed !== 2'b00 || release_pulse !== 2'b11)
      $display("FAIL simul_release: observed pressed=%b pulse=%b, required 00/11", pressed, release_pulse);
    else pass_cnt++;
    repeat (3) @(negedge CLK);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL simul_pending: observed %0d events left, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_press();
    test_reset_mid_press();
    test_simultaneous();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed run still active at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
